// File: rtl/edit_field_ctrl_pkg.sv
// Shared field codes, group codes and step FSM types for the edit-field front-end.
// Also holds helpers that map a group to its field codes and step between fields.
package edit_field_ctrl_pkg;

    localparam int CNT_W = 26;

    localparam logic [3:0] FLD_NONE = 4'd0;
    localparam logic [3:0] FLD_SS   = 4'd1;
    localparam logic [3:0] FLD_MM   = 4'd2;
    localparam logic [3:0] FLD_HH   = 4'd3;
    localparam logic [3:0] FLD_DD   = 4'd4;
    localparam logic [3:0] FLD_MES  = 4'd5;
    localparam logic [3:0] FLD_AA   = 4'd6;
    localparam logic [3:0] FLD_SS_T = 4'd8;
    localparam logic [3:0] FLD_MM_T = 4'd9;
    localparam logic [3:0] FLD_HH_T = 4'd10;

    localparam logic [1:0] GRP_NONE = 2'd0;
    localparam logic [1:0] GRP_CLK  = 2'd1;
    localparam logic [1:0] GRP_DATE = 2'd2;
    localparam logic [1:0] GRP_TMR  = 2'd3;

    localparam int BTN_UP = 0;
    localparam int BTN_DN = 1;
    localparam int BTN_L  = 2;
    localparam int BTN_R  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_HOLD,
        ST_REPEAT
    } step_st_e;

    function automatic logic [3:0] grp_first(input logic [1:0] g);
        logic [3:0] f;
        case (g)
            GRP_CLK:  f = FLD_SS;
            GRP_DATE: f = FLD_DD;
            GRP_TMR:  f = FLD_SS_T;
            default:  f = FLD_NONE;
        endcase
        return f;
    endfunction

    // Every group spans three consecutive codes starting at its first code.
    function automatic logic [3:0] fld_step(input logic [3:0] code,
                                            input logic [1:0] g,
                                            input logic       fwd);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = grp_first(g);
        hi = lo + 4'd2;
        if (g == GRP_NONE) return FLD_NONE;
        if (fwd) return (code == hi) ? lo : code + 4'd1;
        return (code == lo) ? hi : code - 4'd1;
    endfunction

endpackage

// File: rtl/edit_field_ctrl_debounce_btn.sv
// Button conditioner: 2-FF synchroniser, stability counter, rise pulse.
// Ports: clk, reset, btn_i (raw), level_o (debounced), rise_o (1-clk press).
module debounce_btn #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    // The counter tracks consecutive samples that disagree with the
    // accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            rise_q <= 1'b0;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= sync_q;
                rise_q  <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/edit_field_ctrl.sv
// Edit-path front-end: debounced buttons, field select, step/auto-repeat.
// Ports: clk, reset, btn_up/down/left/right, prog_sel -> en_count, enUP, enDOWN.
module edit_field_ctrl
    import edit_field_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REP_CYCLES  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [1:0] prog_sel,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LD  = CNT_W'(REP_CYCLES - 1);

    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] rise;

    assign raw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_deb
        debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (raw[i]),
            .level_o (lvl[i]),
            .rise_o  (rise[i])
        );
    end

    // Step keys work on levels, field keys on press edges.
    logic unused_bits;
    assign unused_bits = ^{rise[BTN_UP], rise[BTN_DN], lvl[BTN_L], lvl[BTN_R]};

    logic [1:0] prog_q;
    logic [3:0] fld_q, fld_d;
    logic       fld_chg;
    logic       go_r, go_l;

    assign go_r = rise[BTN_R] & ~rise[BTN_L];
    assign go_l = rise[BTN_L] & ~rise[BTN_R];

    always_comb begin
        fld_d = fld_q;
        if (prog_sel != prog_q) begin
            fld_d = grp_first(prog_sel);
        end else if (fld_q != FLD_NONE && go_r) begin
            fld_d = fld_step(fld_q, prog_q, 1'b1);
        end else if (fld_q != FLD_NONE && go_l) begin
            fld_d = fld_step(fld_q, prog_q, 1'b0);
        end
    end

    assign fld_chg = (fld_d != fld_q);

    step_st_e         st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             lock_q, lock_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;
    logic             step;
    logic             up, dn, both, held;

    assign up   = lvl[BTN_UP];
    assign dn   = lvl[BTN_DN];
    assign both = up & dn;
    assign held = dir_q ? up : dn;

    // lock_q blocks a new step sequence after a field change or a
    // both-keys chord until every step key has been released.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        lock_d = lock_q;
        step   = 1'b0;
        if (!up && !dn) begin
            lock_d = 1'b0;
        end else if (fld_chg || both) begin
            lock_d = 1'b1;
        end
        unique case (st_q)
            ST_IDLE: begin
                if (!lock_q && !fld_chg && (up ^ dn)
                    && fld_q != FLD_NONE) begin
                    st_d  = ST_FIRST;
                    dir_d = up;
                end
            end
            ST_FIRST: begin
                if (fld_chg) begin
                    st_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = HOLD_LD;
                    st_d  = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (fld_chg || !held || both) begin
                    st_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    step  = 1'b1;
                    cnt_d = REP_LD;
                    st_d  = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
        up_d = step & dir_q & (fld_q != FLD_NONE);
        dn_d = step & ~dir_q & (fld_q != FLD_NONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prog_q <= GRP_NONE;
            fld_q  <= FLD_NONE;
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            lock_q <= 1'b0;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
        end else begin
            prog_q <= prog_sel;
            fld_q  <= fld_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            lock_q <= lock_d;
            up_q   <= up_d;
            dn_q   <= dn_d;
        end
    end

    assign en_count = fld_q;
    assign enUP     = up_q;
    assign enDOWN   = dn_q;

endmodule
